// File: rtl/serial_frame_sequencer_if.sv
// Frame request, byte stream, shifter control and receiver signals of the serial frame sequencer.
// The sequencer uses the slave view; the environment that feeds it uses the master view.
interface serial_frame_sequencer_if #(
  parameter int LEN_WIDTH  = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  startFrame;
  logic [LEN_WIDTH-1:0]  frameLen;
  logic [DATA_WIDTH-1:0] txData;
  logic                  txValid;
  logic                  txReady;
  logic [DATA_WIDTH-1:0] dataBus;
  logic                  loadData;
  logic                  shiftEnabled;
  logic                  shiftComplete;
  logic                  csN;
  logic                  serClkOut;
  logic                  frameBusy;
  logic                  frameDone;
  logic                  errFlag;

  modport master (
    output startFrame, frameLen, txData, txValid, shiftComplete,
    input  txReady, dataBus, loadData, shiftEnabled, csN, serClkOut,
           frameBusy, frameDone, errFlag
  );

  modport slave (
    input  startFrame, frameLen, txData, txValid, shiftComplete,
    output txReady, dataBus, loadData, shiftEnabled, csN, serClkOut,
           frameBusy, frameDone, errFlag
  );
endinterface

// File: rtl/serial_frame_sequencer.sv
// Feeds a frame of bytes into an 8-bit MSB-first shifter and frames them for the serial receiver.
// 9 bit periods per byte; txValid low at a fetch parks the FSM in WAIT with txReady held high.
module serial_frame_sequencer #(
  parameter int HALF_PERIOD = 4,
  parameter int LEN_WIDTH   = 4,
  parameter int DATA_WIDTH  = 8
) (
  input logic shiftClk,
  input logic reset_n,
  serial_frame_sequencer_if.slave bus
);
  localparam logic [8:0] PH_LAST = 9'(2 * HALF_PERIOD - 1);
  localparam logic [8:0] PH_HALF = 9'(HALF_PERIOD);
  localparam logic [2:0] BIT_TOP = 3'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_WAIT, S_LOAD, S_SHIFT, S_FINISH, S_HOLD
  } state_t;

  state_t                state, state_nx;
  logic [8:0]            ph, ph_nx;
  logic [LEN_WIDTH-1:0]  len_left, len_nx;
  logic [2:0]            bit_cnt, bit_nx;
  logic [DATA_WIDTH-1:0] data_q, data_nx;
  logic                  err_q, err_nx;
  logic                  ready_q, ready_nx;
  logic                  load_q, load_nx;
  logic                  sen_q, sen_nx;
  logic                  csn_q, csn_nx;
  logic                  sclk_q, sclk_nx;
  logic                  busy_q, busy_nx;
  logic                  done_q, done_nx;
  logic                  last, take, capture, pulse_state;

  always_ff @(posedge shiftClk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      ph       <= '0;
      len_left <= '0;
      bit_cnt  <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      load_q   <= 1'b0;
      sen_q    <= 1'b0;
      csn_q    <= 1'b1;
      sclk_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      ph       <= ph_nx;
      len_left <= len_nx;
      bit_cnt  <= bit_nx;
      data_q   <= data_nx;
      err_q    <= err_nx;
      ready_q  <= ready_nx;
      load_q   <= load_nx;
      sen_q    <= sen_nx;
      csn_q    <= csn_nx;
      sclk_q   <= sclk_nx;
      busy_q   <= busy_nx;
      done_q   <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ph_nx    = ph;
    len_nx   = len_left;
    bit_nx   = bit_cnt;
    data_nx  = data_q;
    err_nx   = err_q;
    capture  = 1'b0;
    last     = (ph == PH_LAST);
    take     = bus.txValid && ready_q;

    if (state != S_IDLE && state != S_WAIT) ph_nx = last ? '0 : ph + 9'd1;

    case (state)
      S_IDLE: begin
        if (bus.startFrame && bus.frameLen != '0) begin
          state_nx = S_SETUP;
          ph_nx    = '0;
          len_nx   = bus.frameLen;
          err_nx   = 1'b0;
        end
      end
      S_SETUP: begin
        if (last) begin
          capture  = take;
          state_nx = take ? S_LOAD : S_WAIT;
        end
      end
      S_WAIT: begin
        if (take) begin
          capture  = 1'b1;
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        if (last) begin
          state_nx = S_SHIFT;
          bit_nx   = BIT_TOP;
        end
      end
      S_SHIFT: begin
        if (last) begin
          if (bit_cnt == 3'd1) state_nx = S_FINISH;
          else                 bit_nx   = bit_cnt - 3'd1;
        end
      end
      S_FINISH: begin
        if (last) begin
          // The 8th shift edge happened at the start of this period.
          if (!bus.shiftComplete) err_nx = 1'b1;
          if (len_left == '0) begin
            state_nx = S_HOLD;
          end else begin
            capture  = take;
            state_nx = take ? S_LOAD : S_WAIT;
          end
        end
      end
      S_HOLD: begin
        if (last) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    if (capture) begin
      data_nx = bus.txData;
      len_nx  = len_left - LEN_WIDTH'(1);
    end

    // Outputs are registered from the next state so each one lines up with its own period.
    pulse_state = (state_nx == S_LOAD) || (state_nx == S_SHIFT) || (state_nx == S_FINISH);
    sen_nx   = pulse_state && (ph_nx < PH_HALF);
    sclk_nx  = ((state_nx == S_LOAD) || (state_nx == S_SHIFT)) && (ph_nx >= PH_HALF);
    load_nx  = (state_nx == S_LOAD);
    csn_nx   = (state_nx == S_IDLE);
    busy_nx  = (state_nx != S_IDLE);
    done_nx  = (state_nx == S_HOLD) && (ph_nx == PH_LAST);
    ready_nx = (state_nx == S_WAIT) ||
               ((ph_nx == PH_LAST) &&
                ((state_nx == S_SETUP) || ((state_nx == S_FINISH) && (len_nx != '0))));
  end

  assign bus.txReady      = ready_q;
  assign bus.dataBus      = data_q;
  assign bus.loadData     = load_q;
  assign bus.shiftEnabled = sen_q;
  assign bus.csN          = csn_q;
  assign bus.serClkOut    = sclk_q;
  assign bus.frameBusy    = busy_q;
  assign bus.frameDone    = done_q;
  assign bus.errFlag      = err_q;
endmodule
